// File: rtl/id_ex_elastic_stage.sv
// ID->EX pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// All outputs come straight from registers; flush turns held entries into bubbles.
module id_ex_elastic_stage #(
  parameter int DATA_W     = 101,
  parameter int CTRL_W     = 6,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              mv, sv;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              accept, advance;

  assign in_ready  = ~sv;
  assign out_valid = mv;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;

  assign accept  = in_valid & ~sv;
  // M can take a new value when it is empty or being consumed this cycle
  assign advance = ~mv | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv        <= 1'b0;
      sv        <= 1'b0;
      m_data    <= '0;
      s_data    <= '0;
      m_ctrl    <= '0;
      s_ctrl    <= '0;
      occupancy <= 2'd0;
    end else if (flush) begin
      mv        <= 1'b0;
      sv        <= 1'b0;
      m_ctrl    <= '0;
      s_ctrl    <= '0;
      occupancy <= 2'd0;
      if (CLEAR_DATA) begin
        m_data <= '0;
        s_data <= '0;
      end
    end else if (advance) begin
      if (sv) begin
        mv     <= 1'b1;
        m_data <= s_data;
        m_ctrl <= s_ctrl;
        if (accept) begin
          s_data    <= in_data;
          s_ctrl    <= in_ctrl;
          occupancy <= 2'd2;
        end else begin
          sv        <= 1'b0;
          s_ctrl    <= '0;
          occupancy <= 2'd1;
          if (CLEAR_DATA) s_data <= '0;
        end
      end else if (accept) begin
        mv        <= 1'b1;
        m_data    <= in_data;
        m_ctrl    <= in_ctrl;
        occupancy <= 2'd1;
      end else begin
        mv        <= 1'b0;
        m_ctrl    <= '0;
        occupancy <= 2'd0;
        if (CLEAR_DATA) m_data <= '0;
      end
    end else if (accept) begin
      sv        <= 1'b1;
      s_data    <= in_data;
      s_ctrl    <= in_ctrl;
      occupancy <= 2'd2;
    end
  end

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// Bench for id_ex_elastic_stage: directed handshake scenarios, then a randomised
// stream against a queue-based model; two instances cover both CLEAR_DATA settings.
module tb_id_ex_elastic_stage;
  localparam int DW = 101;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DW-1:0] out_data0, out_data1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [1:0]    occ0, occ1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  ent_t          q[$];
  logic [DW-1:0] last_d;
  logic          acc_last;

  always #5 clk = ~clk;

  id_ex_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) dut_hold (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occ0)
  );

  id_ex_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) dut_clear (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
    .occupancy(occ1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model view: the stage is an in-order FIFO of depth 2 whose head is shown on out_*
  task automatic compare_all();
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ev = (q.size() > 0);
    ec = ev ? q[0].c : '0;
    ed = ev ? q[0].d : '0;
    check("out_valid",   {127'd0, out_valid0}, {127'd0, ev});
    check("out_ctrl",    {122'd0, out_ctrl0}, {122'd0, ec});
    check("occupancy",   {126'd0, occ0}, 128'(q.size()));
    check("in_ready",    {127'd0, in_ready0}, {127'd0, (q.size() < 2)});
    check("out_data_hold",  {27'd0, out_data0}, {27'd0, ev ? q[0].d : last_d});
    check("out_valid_clr",  {127'd0, out_valid1}, {127'd0, ev});
    check("out_ctrl_clr",   {122'd0, out_ctrl1}, {122'd0, ec});
    check("out_data_clr",   {27'd0, out_data1}, {27'd0, ed});
  endtask

  task automatic step();
    logic acc, drn;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{d: in_data, c: in_ctrl});
    end
    if (q.size() > 0) last_d = q[0].d;
    acc_last = acc && !flush;
    #1;
    compare_all();
  endtask

  task automatic send(input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [DW-1:0] keep;
    int            seq_in, seq_out, cyc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0; last_d = '0; acc_last = 1'b0;
    #12;
    check("rst_out_valid", {127'd0, out_valid0}, 128'd0);
    check("rst_occupancy", {126'd0, occ0}, 128'd0);
    check("rst_out_data",  {27'd0, out_data0}, 128'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {127'd0, in_ready0}, 128'd1);

    // streaming at full rate
    out_ready = 1'b1;
    send(6'h21); step(); check("stream0", {122'd0, out_ctrl0}, 128'h21);
    send(6'h05); step(); check("stream1", {122'd0, out_ctrl0}, 128'h05);
    send(6'h3F); step(); check("stream2", {122'd0, out_ctrl0}, 128'h3F);
    in_valid = 1'b0; step();

    // back-pressure fills the skid register
    out_ready = 1'b0;
    send(6'h11); step();
    send(6'h22); step();
    check("bp_ctrl", {122'd0, out_ctrl0}, 128'h11);
    check("bp_occ",  {126'd0, occ0}, 128'd2);
    check("bp_rdy",  {127'd0, in_ready0}, 128'd0);
    send(6'h33); step(); step();
    check("bp_hold", {122'd0, out_ctrl0}, 128'h11);
    out_ready = 1'b1;
    step(); check("bp_out1", {122'd0, out_ctrl0}, 128'h22);
    step(); check("bp_out2", {122'd0, out_ctrl0}, 128'h33);
    in_valid = 1'b0;
    step(); check("bp_empty", {127'd0, out_valid0}, 128'd0);

    // flush with a full buffer and a same-cycle input
    out_ready = 1'b0;
    send(6'h01); step();
    send(6'h02); step();
    check("fl_occ_pre", {126'd0, occ0}, 128'd2);
    flush = 1'b1; send(6'h3F); step();
    check("fl_valid", {127'd0, out_valid0}, 128'd0);
    check("fl_ctrl",  {122'd0, out_ctrl0}, 128'd0);
    check("fl_occ",   {126'd0, occ0}, 128'd0);
    check("fl_rdy",   {127'd0, in_ready0}, 128'd1);
    flush = 1'b0; in_valid = 1'b0; step();
    check("fl_gone", {127'd0, out_valid0}, 128'd0);

    // drain to bubble
    out_ready = 1'b1;
    send(6'h0A); keep = in_data; step();
    check("db_ctrl", {122'd0, out_ctrl0}, 128'h0A);
    in_valid = 1'b0; step();
    check("db_valid",     {127'd0, out_valid0}, 128'd0);
    check("db_ctrl0",     {122'd0, out_ctrl0}, 128'd0);
    check("db_data_hold", {27'd0, out_data0}, {27'd0, keep});
    check("db_data_clr",  {27'd0, out_data1}, 128'd0);

    // asynchronous reset while stalled and full
    out_ready = 1'b0;
    send(6'h15); step();
    send(6'h2A); step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {127'd0, out_valid0}, 128'd0);
    check("ar_ctrl",  {122'd0, out_ctrl0}, 128'd0);
    check("ar_occ",   {126'd0, occ0}, 128'd0);
    check("ar_occ_clr", {126'd0, occ1}, 128'd0);
    q.delete(); last_d = '0;
    #1 rst = 1'b0;
    #1;
    check("ar_rdy", {127'd0, in_ready0}, 128'd1);
    out_ready = 1'b1;
    send(6'h19); step();
    check("ar_lat", {122'd0, out_ctrl0}, 128'h19);
    in_valid = 1'b0; step();

    // randomised handshake with incrementing payload
    seq_in = 0; seq_out = 0; cyc = 0; acc_last = 1'b0;
    while (seq_out < 1000 && cyc < 20000) begin
      if (!in_valid || acc_last) begin
        if (seq_in < 1000 && $urandom_range(0, 1) == 1) begin
          in_valid = 1'b1;
          in_data  = '0;
          in_data[31:0] = seq_in;
          in_ctrl  = CW'($urandom);
          seq_in++;
        end else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid0 && out_ready) begin
        check("sb_order", {27'd0, out_data0}, 128'(seq_out));
        seq_out++;
      end
      step();
      cyc++;
    end
    check("sb_count", 128'(seq_out), 128'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
